// File: rtl/alu_mp_seq.sv
// ---------------------------------------------------------------------------
// alu_mp_seq
//
// Sequencer that runs 8..32-bit multi-precision operations through an external
// 8-bit combinational ALU, one byte per clock cycle.
//
// Accepts one command at a time:
//   - add class:         ADD, SUB, ADC, SBC, LSL (LSB-first)
//   - shift-right class: ASR, LSR, RRC (MSB-first, via the ALU's RRC op)
//   - logic ops:         0100..0111 (bytewise)
// Ops 1011, 1100, 1110 and 1111 are rejected with res_err.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_op[3:0]                  operation code
//   cmd_len[1:0]                 byte count minus one
//   cmd_a[31:0], cmd_b[31:0]     operands
//   alu_d0/alu_d1/alu_op/alu_c_in
//                                drive the external 8-bit ALU (0 when not executing)
//   alu_y/alu_c_out              ALU result byte and carry-out
//   res_valid/res_ready          result handshake
//   res_data[31:0]               result; bytes beyond the operand length read 0
//   res_carry                    persistent carry flag
//   res_err                      unsupported-op indication
//   res_zero                     result bytes all zero (optional)
//
// Configuration macro
//   ALU_SEQ_ZERO_FLAG_EN         when defined, adds the res_zero output
// ---------------------------------------------------------------------------
module alu_mp_seq (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,

    output logic [7:0]  alu_d0,
    output logic [7:0]  alu_d1,
    output logic [3:0]  alu_op,
    output logic        alu_c_in,
    input  logic [7:0]  alu_y,
    input  logic        alu_c_out,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_carry,
    output logic        res_err
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic        res_zero
`endif
);

    // Operation codes
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADC = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0011;
    localparam logic [3:0] OP_ASR = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_LSR = 4'b1010;
    localparam logic [3:0] OP_RRC = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_q, state_d;

    logic [3:0]  op_q;
    logic [1:0]  len_q;      // N-1
    logic [1:0]  cnt_q;      // bytes processed so far in EXEC
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        chain_q;    // carry passed between bytes of one operation
    logic        carry_q;    // architectural carry flag, persists across commands
    logic [31:0] data_q;
    logic        err_q;

    logic [1:0]  byte_idx;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic        first_byte;

    // -----------------------------------------------------------------------
    // Op classification
    // -----------------------------------------------------------------------
    function automatic logic op_supported(input logic [3:0] op);
        return !((op == 4'b1011) || (op == 4'b1100) ||
                 (op == 4'b1110) || (op == 4'b1111));
    endfunction

    function automatic logic op_is_shr(input logic [3:0] op);
        return (op == OP_ASR) || (op == OP_LSR) || (op == OP_RRC);
    endfunction

    function automatic logic op_is_logic(input logic [3:0] op);
        return (op[3:2] == 2'b01);
    endfunction

    // -----------------------------------------------------------------------
    // Byte selection: shift-right walks from the top byte down so the bit
    // shifted out of byte i+1 enters byte i through the chain carry.
    // -----------------------------------------------------------------------
    assign first_byte = (cnt_q == 2'd0);
    assign byte_idx   = op_is_shr(op_q) ? (len_q - cnt_q) : cnt_q;
    assign a_byte     = a_q[{byte_idx, 3'b000} +: 8];
    assign b_byte     = b_q[{byte_idx, 3'b000} +: 8];

    // -----------------------------------------------------------------------
    // ALU drive; everything is held at zero outside EXEC
    // -----------------------------------------------------------------------
    always_comb begin
        alu_d0   = 8'h00;
        alu_d1   = 8'h00;
        alu_op   = 4'b0000;
        alu_c_in = 1'b0;
        if (state_q == EXEC) begin
            case (op_q)
                OP_ADD: begin
                    alu_d0   = a_byte;
                    alu_d1   = b_byte;
                    alu_op   = first_byte ? OP_ADD : OP_ADC;
                    alu_c_in = first_byte ? 1'b0 : chain_q;
                end
                OP_SUB: begin
                    alu_d0   = a_byte;
                    alu_d1   = b_byte;
                    alu_op   = first_byte ? OP_SUB : OP_SBC;
                    alu_c_in = first_byte ? 1'b0 : chain_q;
                end
                OP_ADC, OP_SBC: begin
                    alu_d0   = a_byte;
                    alu_d1   = b_byte;
                    alu_op   = op_q;
                    alu_c_in = first_byte ? carry_q : chain_q;
                end
                OP_LSL: begin
                    // A + A is a left shift by one
                    alu_d0   = a_byte;
                    alu_d1   = a_byte;
                    alu_op   = first_byte ? OP_ADD : OP_ADC;
                    alu_c_in = first_byte ? 1'b0 : chain_q;
                end
                OP_ASR, OP_LSR, OP_RRC: begin
                    alu_d0 = a_byte;
                    alu_op = OP_RRC;
                    if (!first_byte) begin
                        alu_c_in = chain_q;
                    end else if (op_q == OP_ASR) begin
                        alu_c_in = a_q[{len_q, 3'b111}];  // replicate sign bit
                    end else if (op_q == OP_RRC) begin
                        alu_c_in = carry_q;
                    end else begin
                        alu_c_in = 1'b0;
                    end
                end
                default: begin
                    if (op_is_logic(op_q)) begin
                        alu_d0 = a_byte;
                        alu_d1 = b_byte;
                        alu_op = op_q;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = op_supported(cmd_op) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (cnt_q == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand latch, byte capture and flag update
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 4'b0000;
            len_q   <= 2'd0;
            cnt_q   <= 2'd0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            chain_q <= 1'b0;
            carry_q <= 1'b0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        len_q   <= cmd_len;
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        cnt_q   <= 2'd0;
                        chain_q <= 1'b0;
                        // Clearing here keeps bytes beyond the length at zero
                        data_q  <= 32'h0;
                        err_q   <= !op_supported(cmd_op);
                    end
                end
                EXEC: begin
                    data_q[{byte_idx, 3'b000} +: 8] <= alu_y;
                    chain_q <= alu_c_out;
                    cnt_q   <= cnt_q + 2'd1;
                    if (cnt_q == len_q) begin
                        carry_q <= op_is_logic(op_q) ? 1'b0 : alu_c_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Result outputs
    // -----------------------------------------------------------------------
    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign res_data  = data_q;
    assign res_carry = carry_q;
    assign res_err   = err_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    // Unused upper bytes are already zero, so the whole word can be tested.
    assign res_zero = (state_q == DONE) && !err_q && (data_q == 32'h0);
`endif

endmodule
